// File: rtl/uart_digit_rx_pkg.sv
// Shared types and constants for the packed-BCD UART receiver.
// Build option: UART_DIGIT_RX_PARITY_EN adds an even-parity bit after the data bits.
package uart_digit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Width of the byte index; a one-byte frame still needs a 1-bit register.
    function automatic int idx_w(input int num_digits);
        return (num_digits > 2) ? $clog2(num_digits / 2) : 1;
    endfunction

endpackage

// File: rtl/uart_digit_rx_if.sv
// Receiver bus: serial input, clear, digit outputs, error pulses and debug view of FSM/byte index.
// Handshake: no valid/ready; frame_done and err_* are single-cycle pulses, digits hold until the next commit.
interface uart_digit_rx_if
    import uart_digit_pkg::*;
#(
    parameter int NUM_DIGITS = 8
);

    localparam int IDX_W = idx_w(NUM_DIGITS);

    logic                      uart_receive;
    logic                      clear;
    logic [NUM_DIGITS*4-1:0]   digits;
    logic                      digits_valid;
    logic                      frame_done;
    logic                      err_frame;
    logic                      err_parity;
    logic                      err_bcd;
    state_t                    dbg_state;
    logic [IDX_W-1:0]          dbg_byte_idx;

    modport master (
        output uart_receive, clear,
        input  digits, digits_valid, frame_done, err_frame, err_parity, err_bcd,
        input  dbg_state, dbg_byte_idx
    );

    modport slave (
        input  uart_receive, clear,
        output digits, digits_valid, frame_done, err_frame, err_parity, err_bcd,
        output dbg_state, dbg_byte_idx
    );

endinterface

// File: rtl/uart_digit_rx_core.sv
// Byte-level UART receiver: 2-FF synchronizer, bit FSM, optional parity (UART_DIGIT_RX_PARITY_EN).
// byte_valid / frame_err / parity_err are combinational in the sampling cycle.
module uart_rx_core
    import uart_digit_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
)(
    input  logic                 iclk,
    input  logic                 reset_n,
    input  logic                 rx_async,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output state_t               state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rx;
    state_t               state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_ok;

    assign rx = sync_q[1];
    assign rx_byte = shreg;

`ifdef UART_DIGIT_RX_PARITY_EN
    logic par_bad, par_bad_n;
    assign par_ok = !par_bad;

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) par_bad <= 1'b0;
        else          par_bad <= par_bad_n;
    end
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_async};
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
`ifdef UART_DIGIT_RX_PARITY_EN
        par_bad_n  = par_bad;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx) state_n = START;
            end
            START: begin
                // Mid-start sample re-phases every later sample to bit centres.
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {rx, shreg[DATA_BITS-1:1]};
                    bit_idx_n = bit_idx + 3'd1;
`ifdef UART_DIGIT_RX_PARITY_EN
                    if (bit_idx == BIT_LAST) state_n = PARITY;
`else
                    if (bit_idx == BIT_LAST) state_n = STOP;
`endif
                end
            end
`ifdef UART_DIGIT_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n      = '0;
                    par_bad_n  = ^{rx, shreg};
                    parity_err = par_bad_n;
                    state_n    = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rx)         frame_err  = 1'b1;
                    else if (par_ok) byte_valid = 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_digit_rx.sv
// Packed-BCD UART frame receiver: packs bytes into a shadow register and commits whole valid frames.
// Build option: UART_DIGIT_RX_PARITY_EN enables the parity bit check in uart_rx_core.
module uart_digit_rx
    import uart_digit_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_DIGITS   = 8
)(
    input  logic iclk,
    input  logic reset_n,
    uart_digit_rx_if.slave bus
);

    localparam int NUM_BYTES = NUM_DIGITS / 2;
    localparam int W = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W = idx_w(NUM_DIGITS);

    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_valid, frame_err, parity_err;
    state_t               core_state;

    logic [IDX_W-1:0] byte_idx;
    logic [W-1:0]     shadow, shadow_merged, digits_q;
    logic             bad, nib_bad, last_byte;
    logic             digits_valid_q, frame_done_q, err_frame_q, err_parity_q, err_bcd_q;
    int               base;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .iclk       (iclk),
        .reset_n    (reset_n),
        .rx_async   (bus.uart_receive),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .state      (core_state)
    );

    // Byte k lands on digits NUM_DIGITS-1-2k (high nibble) and NUM_DIGITS-2-2k (low nibble).
    always_comb begin
        shadow_merged = shadow;
        base = 2 * DIGIT_W * (NUM_BYTES - 1 - int'(byte_idx));
        shadow_merged[base +: 2*DIGIT_W] = rx_byte;
        nib_bad = (rx_byte[2*DIGIT_W-1:DIGIT_W] > BCD_MAX) || (rx_byte[DIGIT_W-1:0] > BCD_MAX);
        last_byte = (byte_idx == IDX_W'(NUM_BYTES - 1));
    end

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx       <= '0;
            shadow         <= '0;
            bad            <= 1'b0;
            digits_q       <= '0;
            digits_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            err_frame_q    <= 1'b0;
            err_parity_q   <= 1'b0;
            err_bcd_q      <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            err_bcd_q    <= 1'b0;
            err_frame_q  <= frame_err;
            err_parity_q <= parity_err;
            if (bus.clear) begin
                byte_idx <= '0;
                shadow   <= '0;
                bad      <= 1'b0;
            end else if (byte_valid) begin
                shadow <= shadow_merged;
                if (last_byte) begin
                    byte_idx <= '0;
                    bad      <= 1'b0;
                    if (bad || nib_bad) begin
                        err_bcd_q <= 1'b1;
                    end else begin
                        digits_q       <= shadow_merged;
                        frame_done_q   <= 1'b1;
                        digits_valid_q <= 1'b1;
                    end
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                    bad      <= bad || nib_bad;
                end
            end
        end
    end

    assign bus.digits       = digits_q;
    assign bus.digits_valid = digits_valid_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.err_frame    = err_frame_q;
    assign bus.err_parity   = err_parity_q;
    assign bus.err_bcd      = err_bcd_q;
    assign bus.dbg_state    = core_state;
    assign bus.dbg_byte_idx = byte_idx;

endmodule
